// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state codes,
// funct3 encodings, access-size codes and decode helpers.
package lsu_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Legal funct3 for the given direction and data width.
  function automatic logic f3_legal(input logic st, input logic [2:0] f3,
                                    input logic xlen64);
    if (st)
      return (f3[2] == 1'b0) && (xlen64 || (f3 != F3_SD));
    else
      return (f3 != 3'b111) && (xlen64 || ((f3 != F3_LD) && (f3 != F3_LWU)));
  endfunction

  // Byte-lane mask covering an access of the given size code.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response bundle between a pipeline and the load/store unit.
interface lsu_if #(parameter int XLEN = 64);
  logic            req_valid;
  logic            req_ready;
  logic            is_store;
  logic [2:0]      funct3;
  logic [XLEN-1:0] base;
  logic [11:0]     offset;
  logic [XLEN-1:0] store_data;
  logic            resp_valid;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] addr_out;
  logic            err;

  modport master (
    output req_valid, is_store, funct3, base, offset, store_data,
    input  req_ready, resp_valid, load_data, addr_out, err
  );

  modport slave (
    input  req_valid, is_store, funct3, base, offset, store_data,
    output req_ready, resp_valid, load_data, addr_out, err
  );
endinterface

// File: rtl/lsu_data_mem.sv
// Byte-addressed data memory: one multi-byte port, per-byte write
// enables, combinational read. Lane k addresses (addr + k) mod DEPTH,
// so accesses crossing the top of memory wrap to byte 0.
module lsu_data_mem #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH),
  localparam int NB   = XLEN / 8
) (
  input  logic            clk,
  input  logic [AW-1:0]   addr,
  input  logic [NB-1:0]   we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [7:0] mem [DEPTH];

  // Byte-lane writes; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++)
      if (we[k]) mem[addr + AW'(k)] <= wdata[8*k +: 8];
  end

  // Little-endian gather of NB consecutive bytes.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NB; k++)
      rdata[8*k +: 8] = mem[addr + AW'(k)];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP.
// Optional macro LSU_MISALIGN_TRAP_EN makes misaligned accesses fault;
// without it they are performed bytewise.
//
// state     | meaning
// ST_IDLE   | ready for a request
// ST_ACCESS | memory access in progress, store commits on last cycle
// ST_RESP   | one-cycle response
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input logic clk,
  input logic reset,
  lsu_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic            st_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] sdata_q;
  logic [XLEN-1:0] eff_addr;
  logic            accept;
  logic            last_access;
  logic [7:0]      mask8;
  logic [2:0]      align_mask;
  logic            misalign;
  logic            fault;
  logic [NB-1:0]   we;
  logic [XLEN-1:0] rdata;
  logic [63:0]     r64;
  logic [63:0]     ext64;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] load_data_q;
  logic [XLEN-1:0] addr_out_q;
  logic            err_q;

  assign eff_addr    = bus.base + {{(XLEN-12){bus.offset[11]}}, bus.offset};
  assign accept      = (state == ST_IDLE) && bus.req_valid;
  assign last_access = (state == ST_ACCESS) && (cnt == '0);
  assign mask8       = size_mask(f3_q[1:0]);
  // Low address bits that must be zero for a naturally aligned access.
  assign align_mask  = {mask8[7], mask8[3], mask8[1]};

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = |(addr_q[2:0] & align_mask);
`else
  assign misalign = 1'b0;
`endif

  assign fault = !f3_legal(st_q, f3_q, XLEN == 64) || misalign;
  assign we    = (last_access && st_q && !fault) ? mask8[NB-1:0] : '0;

  lsu_data_mem #(.XLEN(XLEN), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .addr  (addr_q[AW-1:0]),
    .we    (we),
    .wdata (sdata_q),
    .rdata (rdata)
  );

  assign r64 = 64'(rdata);

  // Size select with sign or zero extension (funct3[2] = unsigned).
  always_comb begin
    ext64 = r64;
    case (f3_q[1:0])
      SZ_B: ext64 = {{56{r64[7]  & ~f3_q[2]}}, r64[7:0]};
      SZ_H: ext64 = {{48{r64[15] & ~f3_q[2]}}, r64[15:0]};
      SZ_W: ext64 = {{32{r64[31] & ~f3_q[2]}}, r64[31:0]};
      default: ext64 = r64;
    endcase
  end

  assign result = (st_q || fault) ? '0 : ext64[XLEN-1:0];

  // State machine, latency down-counter and request capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      st_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          state   <= ST_ACCESS;
          cnt     <= CW'(MEM_LATENCY - 1);
          st_q    <= bus.is_store;
          f3_q    <= bus.funct3;
          addr_q  <= eff_addr;
          sdata_q <= bus.store_data;
        end
        ST_ACCESS: begin
          if (cnt == '0) state <= ST_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response registers update on the final ACCESS edge and hold until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_data_q <= '0;
      addr_out_q  <= '0;
      err_q       <= 1'b0;
    end else if (last_access) begin
      load_data_q <= result;
      addr_out_q  <= addr_q;
      err_q       <= fault;
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.load_data  = load_data_q;
  assign bus.addr_out   = addr_out_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=64, DEPTH=256, MEM_LATENCY=2).
module tb_load_store_unit;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [63:0] r_data;
  logic [63:0] r_addr;
  logic        r_err;
  int          r_lat;
  logic        r_rdy_access;

  lsu_if #(.XLEN(64)) bus ();

  load_store_unit #(.XLEN(64), .DEPTH(256), .MEM_LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Issue one request and wait (bounded) for its response.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [63:0] b,
                        input logic [11:0] off, input logic [63:0] d);
    int n;
    bit got;
    @(negedge clk);
    bus.is_store   = st;
    bus.funct3     = f3;
    bus.base       = b;
    bus.offset     = off;
    bus.store_data = d;
    bus.req_valid  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    r_lat = 0;
    got   = 1'b0;
    while (!got && r_lat < 20) begin
      @(negedge clk);
      r_lat++;
      if (r_lat == 1) r_rdy_access = bus.req_ready;
      if (bus.resp_valid) got = 1'b1;
    end
    if (!got) check("resp_timeout", 64'd0, 64'd1);
    r_data = bus.load_data;
    r_err  = bus.err;
    r_addr = bus.addr_out;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.is_store   = 1'b0;
    bus.funct3     = 3'b000;
    bus.base       = '0;
    bus.offset     = '0;
    bus.store_data = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_load_data", bus.load_data, 64'd0);
    check("rst_addr_out", bus.addr_out, 64'd0);
    reset = 1'b0;

    // Seed 0x18 with a known value.
    do_req(1'b1, 3'b011, 64'h18, 12'h000, 64'h0123456789ABCDEF);
    check("seed_err", 64'(r_err), 64'd0);
    check("seed_store_data0", r_data, 64'd0);
    check("seed_addr", r_addr, 64'h18);

    // Reset during ACCESS of SD base=0x10 offset=8: store must be dropped.
    @(negedge clk);
    bus.is_store   = 1'b1;
    bus.funct3     = 3'b011;
    bus.base       = 64'h10;
    bus.offset     = 12'h008;
    bus.store_data = 64'hDEADBEEFCAFEF00D;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("access_not_ready", 64'(bus.req_ready), 64'd0);
    #1 reset = 1'b1;
    #1;
    check("midrst_ready", 64'(bus.req_ready), 64'd1);
    check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("midrst_addr_out", bus.addr_out, 64'd0);
    #1 reset = 1'b0;
    do_req(1'b0, 3'b011, 64'h18, 12'h000, 64'd0);
    check("midrst_ld_data", r_data, 64'h0123456789ABCDEF);
    check("midrst_ld_err", 64'(r_err), 64'd0);

    // Store/load round trip with latency and ready checks.
    do_req(1'b1, 3'b011, 64'h10, 12'h008, 64'h8877665544332211);
    check("sd_ready_in_access", 64'(r_rdy_access), 64'd0);
    do_req(1'b0, 3'b011, 64'h10, 12'h008, 64'd0);
    check("rt_ld_data", r_data, 64'h8877665544332211);
    check("rt_latency", 64'(r_lat), 64'd3);
    check("rt_addr", r_addr, 64'h18);
    @(negedge clk);
    check("post_resp_valid_low", 64'(bus.resp_valid), 64'd0);
    check("post_resp_hold_data", bus.load_data, 64'h8877665544332211);

    // Sign handling.
    do_req(1'b1, 3'b000, 64'h18, 12'h000, 64'hFFFFFFFFFFFFFF80);
    check("sb_load_data0", r_data, 64'd0);
    do_req(1'b0, 3'b000, 64'h18, 12'h000, 64'd0);
    check("lb_signext", r_data, 64'hFFFFFFFFFFFFFF80);
    do_req(1'b0, 3'b100, 64'h18, 12'h000, 64'd0);
    check("lbu_zeroext", r_data, 64'h0000000000000080);

    // Negative offset.
    do_req(1'b0, 3'b011, 64'h20, 12'hFF8, 64'd0);
    check("negoff_addr", r_addr, 64'h18);
    check("negoff_data", r_data, 64'h8877665544332280);

    // Misaligned LW at 0x1A: bytes 0x1D..0x1A = 66 55 44 33.
    do_req(1'b0, 3'b010, 64'h1A, 12'h000, 64'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_lw_err", 64'(r_err), 64'd1);
    check("mis_lw_data", r_data, 64'd0);
`else
    check("mis_lw_err", 64'(r_err), 64'd0);
    check("mis_lw_data", r_data, 64'h0000000066554433);
`endif

    // Illegal codes.
    do_req(1'b0, 3'b111, 64'h18, 12'h000, 64'd0);
    check("ill_ld_err", 64'(r_err), 64'd1);
    check("ill_ld_data", r_data, 64'd0);
    do_req(1'b1, 3'b100, 64'h18, 12'h000, 64'hFFFFFFFFFFFFFFFF);
    check("ill_st_err", 64'(r_err), 64'd1);
    do_req(1'b0, 3'b011, 64'h18, 12'h000, 64'd0);
    check("ill_mem_unchanged", r_data, 64'h8877665544332280);
    check("legal_err_clear", 64'(r_err), 64'd0);

    // SH wrapping past the top of memory.
    do_req(1'b1, 3'b001, 64'hFF, 12'h000, 64'h000000000000BEEF);
`ifdef LSU_MISALIGN_TRAP_EN
    check("wrap_sh_err", 64'(r_err), 64'd1);
`else
    check("wrap_sh_err", 64'(r_err), 64'd0);
    do_req(1'b0, 3'b100, 64'hFF, 12'h000, 64'd0);
    check("wrap_byte_ff", r_data, 64'hEF);
    do_req(1'b0, 3'b100, 64'h00, 12'h000, 64'd0);
    check("wrap_byte_00", r_data, 64'hBE);
    do_req(1'b0, 3'b001, 64'hFF, 12'h000, 64'd0);
    check("wrap_lh_signext", r_data, 64'hFFFFFFFFFFFFBEEF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
